// File: rtl/vector_mem_read_sequencer.sv
//------------------------------------------------------------------------------
// vector_mem_read_sequencer : strided vector-load issue engine with return FIFO
// Revision 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module vector_mem_read_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int NUM_ELEM     = 64,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [ADDR_WIDTH-1:0]            cmd_base,
  input  logic [ADDR_WIDTH-1:0]            cmd_stride,
  input  logic [15:0]                      cmd_count,
  input  logic [NUM_ELEM-1:0]              cmd_lane_mask,
  output logic [NUM_ELEM-1:0]              mem_read_req,
  output logic [ADDR_WIDTH*NUM_ELEM-1:0]   mem_read_addr,
  input  logic [DATA_WIDTH*NUM_ELEM-1:0]   mem_read_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*NUM_ELEM-1:0]   out_data,
  output logic                             out_last,
  output logic                             busy
);

  localparam int VEC_W = DATA_WIDTH * NUM_ELEM;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IF_W  = $clog2(READ_LATENCY + 1);
  localparam int SUM_W = CNT_W + IF_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   stride_q, stride_d;
  logic [15:0]             remaining_q, remaining_d;
  logic [NUM_ELEM-1:0]     mask_q, mask_d;

  logic [READ_LATENCY-1:0] pipe_valid_q, pipe_valid_d;
  logic [READ_LATENCY-1:0] pipe_last_q, pipe_last_d;
  logic [NUM_ELEM-1:0]     pipe_mask_q [READ_LATENCY];
  logic [NUM_ELEM-1:0]     pipe_mask_d [READ_LATENCY];

  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        fifo_count_q, fifo_count_d;
  logic [VEC_W-1:0]        fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_last_q;

  logic [IF_W-1:0]         inflight;
  logic                    issue;
  logic                    push;
  logic                    pop;
  logic [VEC_W-1:0]        push_data;

  // Every slot in the return pipe is a reserved FIFO entry, so a push can never overflow.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + IF_W'(pipe_valid_q[i]);
    end
  end

  assign issue = (state_q == ST_ISSUE) &&
                 ((SUM_W'(fifo_count_q) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH));
  assign push  = pipe_valid_q[READ_LATENCY-1];
  assign pop   = out_valid && out_ready;

  assign cmd_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign mem_read_req = issue ? mask_q : '0;

  genvar l;
  generate
    for (l = 0; l < NUM_ELEM; l++) begin : g_lane
      assign mem_read_addr[l*ADDR_WIDTH +: ADDR_WIDTH] = issue ? addr_q : '0;
      assign push_data[l*DATA_WIDTH +: DATA_WIDTH] =
        mem_read_data[l*DATA_WIDTH +: DATA_WIDTH] &
        {DATA_WIDTH{pipe_mask_q[READ_LATENCY-1][l]}};
    end
  endgenerate

  assign out_valid = (fifo_count_q != '0);
  assign out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign out_last  = out_valid && fifo_last_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    remaining_d = remaining_q;
    mask_d      = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && (cmd_count != 16'd0)) begin
          addr_d      = cmd_base;
          stride_d    = cmd_stride;
          remaining_d = cmd_count;
          mask_d      = cmd_lane_mask;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          addr_d      = addr_q + stride_q;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if ((inflight == '0) && (fifo_count_q == '0)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pipe_valid_d[0] = issue;
    pipe_last_d[0]  = (remaining_q == 16'd1);
    pipe_mask_d[0]  = mask_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_last_d[i]  = pipe_last_q[i-1];
      pipe_mask_d[i]  = pipe_mask_q[i-1];
    end
  end

  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (push && !pop) begin
      fifo_count_d = fifo_count_q + CNT_W'(1);
    end else if (pop && !push) begin
      fifo_count_d = fifo_count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      stride_q     <= '0;
      remaining_q  <= '0;
      mask_q       <= '0;
      pipe_valid_q <= '0;
      pipe_last_q  <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_mask_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      stride_q     <= stride_d;
      remaining_q  <= remaining_d;
      mask_q       <= mask_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_last_q  <= pipe_last_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_mask_q[i] <= pipe_mask_d[i];
      end
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  // Storage needs no reset: reads are gated by fifo_count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_last_q[wr_ptr_q] <= pipe_last_q[READ_LATENCY-1];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vector_mem_read_sequencer.sv
//------------------------------------------------------------------------------
// tb_vector_mem_read_sequencer : randomized bench with a queue-based reference model
// Revision 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_vector_mem_read_sequencer;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int NE = 64;
  localparam int RL = 1;
  localparam int FD = 4;
  localparam int VW = DW * NE;

  logic           clk = 1'b0;
  logic           reset;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [AW-1:0]  cmd_base;
  logic [AW-1:0]  cmd_stride;
  logic [15:0]    cmd_count;
  logic [NE-1:0]  cmd_lane_mask;
  logic [NE-1:0]  mem_read_req;
  logic [AW*NE-1:0] mem_read_addr;
  logic [VW-1:0]  mem_read_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [VW-1:0]  out_data;
  logic           out_last;
  logic           busy;

  vector_mem_read_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ELEM(NE),
    .READ_LATENCY(RL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride),
    .cmd_count(cmd_count), .cmd_lane_mask(cmd_lane_mask),
    .mem_read_req(mem_read_req), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [VW-1:0] data; logic last; } vec_t;
  typedef struct { logic [AW-1:0] addr; logic [NE-1:0] mask; } iss_t;

  vec_t exp_q[$];
  iss_t iss_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_issues = 0;
  int   n_pops   = 0;
  int   n_lasts  = 0;
  int   ready_mode = 0;   // 0 low, 1 high, 2 random

  iss_t         mon_e;
  vec_t         mon_v;
  logic         mon_eq;
  logic         prev_hold = 1'b0;
  logic [VW-1:0] prev_data;
  logic         prev_last;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_val(input int lane, input logic [AW-1:0] a);
    return (a * 16'd3) ^ DW'(lane * 257) ^ 16'hA5C3;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: one-cycle read latency; idle lanes return junk so masking is exercised.
  always @(posedge clk) begin
    for (int i = 0; i < NE; i++) begin
      mem_read_data[i*DW +: DW] <= mem_read_req[i] ?
        mem_val(i, mem_read_addr[i*AW +: AW]) : DW'($urandom);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (mem_read_req != '0) begin
        n_issues++;
        mon_eq = 1'b1;
        for (int i = 1; i < NE; i++)
          if (mem_read_addr[i*AW +: AW] !== mem_read_addr[AW-1:0]) mon_eq = 1'b0;
        check("issue_addr_lanes_equal", mon_eq, 1'b1);
        if (iss_q.size() == 0) begin
          check("issue_unexpected", 1'b1, 1'b0);
        end else begin
          mon_e = iss_q.pop_front();
          check("issue_req", mem_read_req, mon_e.mask);
          check("issue_addr", mem_read_addr[AW-1:0], mon_e.addr);
        end
      end
      if (prev_hold) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_stable", {out_data == prev_data, out_last == prev_last}, 2'b11);
      end
      if (out_valid && out_ready) begin
        n_pops++;
        if (out_last) n_lasts++;
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 1'b1, 1'b0);
        end else begin
          mon_v = exp_q.pop_front();
          for (int c = 0; c < VW / 256; c++)
            check($sformatf("out_data_chunk%0d", c), out_data[c*256 +: 256], mon_v.data[c*256 +: 256]);
          check("out_last", out_last, mon_v.last);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end
  end

  task automatic set_ready(input int mode);
    ready_mode = mode;
    @(posedge clk);
    #3;
  endtask

  task automatic send_cmd(input logic [AW-1:0] b, input logic [AW-1:0] s,
                          input logic [15:0] c, input logic [NE-1:0] m);
    int   budget = 300;
    vec_t v;
    logic [AW-1:0] a;
    @(negedge clk);
    #1;
    cmd_base = b; cmd_stride = s; cmd_count = c; cmd_lane_mask = m; cmd_valid = 1'b1;
    while (!cmd_ready && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", 1'b0, 1'b1);
      cmd_valid = 1'b0;
      return;
    end
    for (int i = 0; i < int'(c); i++) begin
      a = b + AW'(i) * s;
      for (int ln = 0; ln < NE; ln++)
        v.data[ln*DW +: DW] = m[ln] ? mem_val(ln, a) : '0;
      v.last = (i == int'(c) - 1);
      exp_q.push_back(v);
      if (m != '0) iss_q.push_back('{addr: a, mask: m});
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (k < budget) begin
      @(negedge clk);
      #1;
      if (!busy && !out_valid && exp_q.size() == 0) break;
      k++;
    end
    if (k >= budget) check("idle_timeout", 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cmd_ready"}, cmd_ready, 1'b1);
    check({pfx, "_busy"}, busy, 1'b0);
    check({pfx, "_req"}, mem_read_req, '0);
    check({pfx, "_addr_or"}, |mem_read_addr, 1'b0);
    check({pfx, "_valid"}, out_valid, 1'b0);
    check({pfx, "_data_or"}, |out_data, 1'b0);
    check({pfx, "_last"}, out_last, 1'b0);
  endtask

  initial begin
    int s, p, lst, n, first, last, r;
    logic [NE-1:0] m;
    logic [AW-1:0] st;

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_base = '0; cmd_stride = '0; cmd_count = '0; cmd_lane_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    #1;
    reset = 1'b0;

    // single vector, latency and content
    set_ready(1);
    p = n_pops;
    send_cmd(16'h0010, 16'h0001, 16'd1, '1);
    @(negedge clk); #1;
    check("t1_req", mem_read_req, {NE{1'b1}});
    check("t1_addr_lane0", mem_read_addr[AW-1:0], 16'h0010);
    check("t1_addr_lane63", mem_read_addr[AW*NE-1 -: AW], 16'h0010);
    check("t1_busy", busy, 1'b1);
    @(negedge clk); #1;
    check("t1_req_done", mem_read_req, '0);
    check("t1_valid_early", out_valid, 1'b0);
    @(negedge clk); #1;
    check("t1_valid", out_valid, 1'b1);
    check("t1_last", out_last, 1'b1);
    check("t1_lane5", out_data[5*DW +: DW], mem_val(5, 16'h0010));
    wait_idle(50);
    check("t1_pops", n_pops - p, 1);
    check("t1_busy_after", busy, 1'b0);

    // wrap-around stride
    s = n_issues; p = n_pops; lst = n_lasts;
    send_cmd(16'h0002, 16'hFFFF, 16'd4, {$urandom, $urandom} | 64'h1);
    wait_idle(100);
    check("t2_issues", n_issues - s, 4);
    check("t2_pops", n_pops - p, 4);
    check("t2_lasts", n_lasts - lst, 1);

    // back-pressure: credits stop issue at FIFO_DEPTH
    set_ready(0);
    s = n_issues; p = n_pops;
    send_cmd(16'h1000, 16'h0040, 16'd8, '1);
    repeat (20) @(negedge clk);
    #1;
    check("t3_issues_blocked", n_issues - s, FD);
    check("t3_req_stalled", mem_read_req, '0);
    check("t3_valid_held", out_valid, 1'b1);
    ready_mode = 1;
    n = 0; first = -1; last = -1;
    for (int k = 0; k < 80 && n < 8; k++) begin
      @(negedge clk); #1;
      if (out_valid && out_ready) begin
        if (first < 0) first = cyc;
        last = cyc;
        n++;
      end
    end
    check("t3_delivered", n, 8);
    check("t3_back_to_back", last - first, 7);
    wait_idle(50);
    check("t3_issues_total", n_issues - s, 8);

    // partial lane mask
    send_cmd(16'h0100, 16'h0003, 16'd3, 64'h000000000000000F);
    @(negedge clk); #1;
    check("t4_req", mem_read_req, 64'hF);
    wait_idle(50);

    // zero-length command
    s = n_issues; p = n_pops;
    send_cmd(16'h0055, 16'h0001, 16'd0, '1);
    check("t5_busy_now", busy, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check("t5_busy", busy, 1'b0);
      check("t5_req", mem_read_req, '0);
      check("t5_valid", out_valid, 1'b0);
    end
    check("t5_no_issue", n_issues - s, 0);

    // reset with reads in flight
    set_ready(0);
    s = n_issues;
    send_cmd(16'h2000, 16'h0005, 16'd6, '1);
    for (int k = 0; k < 50 && (n_issues - s) < 2; k++) begin
      @(negedge clk); #1;
    end
    check("t6_two_issued", n_issues - s, 2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    iss_q.delete();
    #1;
    check_reset_outputs("t6_reset");
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("t6_no_stale", out_valid, 1'b0);
    end
    set_ready(1);
    p = n_pops;
    send_cmd(16'h3000, 16'h0001, 16'd1, '1);
    wait_idle(50);
    check("t6_post_reset_pops", n_pops - p, 1);

    // randomized commands under random back-pressure
    ready_mode = 2;
    for (int t = 0; t < 30; t++) begin
      r = $urandom_range(0, 5);
      m = (r == 0) ? '0 : (r == 1) ? '1 : {$urandom, $urandom};
      st = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 4)) : AW'($urandom);
      send_cmd(AW'($urandom), st, 16'($urandom_range(0, 9)), m);
    end
    wait_idle(3000);
    check("final_exp_empty", exp_q.size(), 0);
    check("final_iss_empty", iss_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
